// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, next-PC select codes and word width.
// Also provides the branch-offset sign extension helper.
package instr_fetch_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // Sign-extend an 8-bit branch displacement to a full word.
    function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
        return {{(WORD_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC selector: sequential, relative branch, page jump or register jump.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is loaded.
module next_pc_sel
    import instr_fetch_pkg::*;
(
    input  logic [3:0]        pc_hi_i,
    input  logic [WORD_W-1:0] pc_plus1_i,
    input  logic [11:0]       instr_lo_i,
    input  logic [1:0]        next_sel_i,
    input  logic [WORD_W-1:0] reg_target_i,
    output logic [WORD_W-1:0] next_pc_o
);

    logic [WORD_W-1:0] br_target;
    logic [WORD_W-1:0] jmp_target;

    // Branch is relative to pc+1 and wraps modulo 2^16; jump keeps the current 4K page.
    assign br_target  = pc_plus1_i + sext8(instr_lo_i[7:0]);
    assign jmp_target = {pc_hi_i, instr_lo_i};

    // Four-way target select.
    always_comb begin
        next_pc_o = pc_plus1_i;
        unique case (next_sel_i)
            NPC_SEQ: next_pc_o = pc_plus1_i;
            NPC_BR:  next_pc_o = br_target;
            NPC_JMP: next_pc_o = jmp_target;
            NPC_JR:  next_pc_o = reg_target_i;
            default: next_pc_o = pc_plus1_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads one word at pc, holds it until the consumer advances.
// Latency: ready in cycle N gives instr_valid in N+1; two cycles per instruction minimum.
// Backpressure: waits indefinitely for i_mem_ready in FETCH and for advance in HOLD.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
)(
    input  logic              clk,
    input  logic              reset,
    output logic              i_mem_req,
    output logic [WORD_W-1:0] i_mem_addr,
    input  logic              i_mem_ready,
    input  logic [WORD_W-1:0] i_mem_data,
    input  logic              advance,
    input  logic [1:0]        next_sel,
    input  logic [WORD_W-1:0] reg_target,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus1
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] next_pc;

    assign pc_plus1 = pc_q + 16'd1;

    next_pc_sel u_next_pc_sel (
        .pc_hi_i      (pc_q[15:12]),
        .pc_plus1_i   (pc_plus1),
        .instr_lo_i   (instr_q[11:0]),
        .next_sel_i   (next_sel),
        .reg_target_i (reg_target),
        .next_pc_o    (next_pc)
    );

    // State, PC and instruction registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic; ready is only honoured in FETCH and advance only in HOLD.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (i_mem_ready) begin
                    instr_d = i_mem_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request and valid are pure state decodes, so they are low straight out of reset.
    assign i_mem_req   = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign i_mem_addr  = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        i_mem_req;
    logic [15:0] i_mem_addr;
    logic        i_mem_ready;
    logic [15:0] i_mem_data;
    logic        advance;
    logic [1:0]  next_sel;
    logic [15:0] reg_target;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_mem_req   (i_mem_req),
        .i_mem_addr  (i_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_data  (i_mem_data),
        .advance     (advance),
        .next_sel    (next_sel),
        .reg_target  (reg_target),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus1    (pc_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!i_mem_req && n < 20) begin
            step();
            n++;
        end
        check("req_wait", {31'd0, i_mem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [15:0] d);
        wait_req();
        i_mem_ready = 1'b1;
        i_mem_data  = d;
        step();
        i_mem_ready = 1'b0;
        check("fetch_valid", {31'd0, instr_valid}, 32'd1);
        check("fetch_instr", {16'd0, instr}, {16'd0, d});
    endtask

    task automatic go(input logic [1:0] sel, input logic [15:0] tgt);
        advance    = 1'b1;
        next_sel   = sel;
        reg_target = tgt;
        step();
        advance    = 1'b0;
        next_sel   = 2'd0;
        reg_target = 16'h0000;
        check("go_req", {31'd0, i_mem_req}, 32'd1);
        check("go_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        i_mem_ready = 1'b0;
        i_mem_data  = 16'h0000;
        advance     = 1'b0;
        next_sel    = 2'd0;
        reg_target  = 16'h0000;
        repeat (2) step();

        // Reset state
        check("rst_req",   {31'd0, i_mem_req},   32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc",    {16'd0, pc},          32'h0000);
        check("rst_instr", {16'd0, instr},       32'h0000);
        reset = 1'b0;

        // Cycle 1 (IDLE) -> cycle 2 FETCH -> cycle 3 HOLD
        step();
        check("c2_req",  {31'd0, i_mem_req}, 32'd1);
        check("c2_addr", {16'd0, i_mem_addr}, 32'h0000);
        i_mem_ready = 1'b1;
        i_mem_data  = 16'h1234;
        step();
        i_mem_ready = 1'b0;
        check("c3_instr", {16'd0, instr}, 32'h1234);
        check("c3_valid", {31'd0, instr_valid}, 32'd1);
        check("c3_pc",    {16'd0, pc}, 32'h0000);
        check("c3_req",   {31'd0, i_mem_req}, 32'd0);
        check("c3_pcp1",  {16'd0, pc_plus1}, 32'h0001);

        // Negative branch: 0x10 + 1 + (-2) = 0x0F
        go(2'd3, 16'h0010);
        check("jr_pc", {16'd0, pc}, 32'h0010);
        fetch(16'h50FE);
        go(2'd1, 16'hFFFF);
        check("br_pc",   {16'd0, pc}, 32'h000F);
        check("br_addr", {16'd0, i_mem_addr}, 32'h000F);

        // Wait states; advance/next_sel in FETCH are ignored
        i_mem_data = 16'hDEAD;
        advance    = 1'b1;
        next_sel   = 2'd3;
        reg_target = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_req",   {31'd0, i_mem_req}, 32'd1);
            check("ws_addr",  {16'd0, i_mem_addr}, 32'h000F);
            check("ws_valid", {31'd0, instr_valid}, 32'd0);
        end
        advance    = 1'b0;
        next_sel   = 2'd0;
        reg_target = 16'h0000;
        i_mem_ready = 1'b1;
        i_mem_data  = 16'h9456;
        step();
        check("ws_instr", {16'd0, instr}, 32'h9456);
        check("ws_hold",  {31'd0, instr_valid}, 32'd1);
        // Spurious ready in HOLD
        i_mem_data = 16'hBEEF;
        step();
        i_mem_ready = 1'b0;
        check("spur_instr", {16'd0, instr}, 32'h9456);
        check("spur_valid", {31'd0, instr_valid}, 32'd1);
        check("spur_pc",    {16'd0, pc}, 32'h000F);

        // Page jump and register jump
        go(2'd3, 16'hA123);
        check("a123_pc", {16'd0, pc}, 32'hA123);
        fetch(16'h9456);
        go(2'd2, 16'h0000);
        check("jmp_pc", {16'd0, pc}, 32'hA456);
        fetch(16'h1234);
        go(2'd3, 16'h0BEE);
        check("jr2_pc", {16'd0, pc}, 32'h0BEE);

        // Back-to-back: zero-wait memory, advance high -> 2 cycles per instruction
        i_mem_ready = 1'b1;
        i_mem_data  = 16'h0000;
        advance     = 1'b1;
        next_sel    = 2'd0;
        step();
        check("bb_hold1", {31'd0, instr_valid}, 32'd1);
        check("bb_pc1",   {16'd0, pc}, 32'h0BEE);
        step();
        check("bb_fetch", {31'd0, instr_valid}, 32'd0);
        check("bb_pc2",   {16'd0, pc}, 32'h0BEF);
        step();
        step();
        check("bb_pc3",   {16'd0, pc}, 32'h0BF0);
        i_mem_ready = 1'b0;
        advance     = 1'b0;

        // Sequential wrap at the top of memory
        fetch(16'h0000);
        go(2'd3, 16'hFFFF);
        fetch(16'h0000);
        check("top_pcp1", {16'd0, pc_plus1}, 32'h0000);
        go(2'd0, 16'h0000);
        check("wrap_pc",   {16'd0, pc}, 32'h0000);
        check("wrap_pcp1", {16'd0, pc_plus1}, 32'h0001);

        // Branch below zero: 0 + 1 - 128 = 0xFF81
        fetch(16'h0080);
        go(2'd1, 16'h0000);
        check("brneg_pc",   {16'd0, pc}, 32'hFF81);
        check("brneg_addr", {16'd0, i_mem_addr}, 32'hFF81);

        // Reset during a FETCH wait, overriding ready/advance, then ready in IDLE
        step();
        reset       = 1'b1;
        i_mem_ready = 1'b1;
        advance     = 1'b1;
        i_mem_data  = 16'h5555;
        step();
        check("mr_pc",    {16'd0, pc}, 32'h0000);
        check("mr_req",   {31'd0, i_mem_req}, 32'd0);
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_instr", {16'd0, instr}, 32'h0000);
        reset      = 1'b0;
        advance    = 1'b0;
        i_mem_data = 16'hABCD;
        step();
        i_mem_ready = 1'b0;
        check("idle_rdy_instr", {16'd0, instr}, 32'h0000);
        check("idle_rdy_valid", {31'd0, instr_valid}, 32'd0);
        check("idle_rdy_req",   {31'd0, i_mem_req}, 32'd1);
        check("idle_rdy_addr",  {16'd0, i_mem_addr}, 32'h0000);
        fetch(16'h4321);
        check("restart_pc", {16'd0, pc}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
